// File: rtl/dct_zigzag_serializer_if.sv
// Stream bundle between the DCT stage, the zigzag serializer and the quantiser path.
// The serializer connects through the slave modport; the block source and sink use master.
interface dct_zigzag_serializer_if #(
  parameter int COEF_W = 10,
  parameter int NCOEF  = 64
);
  logic                    in_valid;
  logic [NCOEF*COEF_W-1:0] coef_in;
  logic                    in_ready;
  logic [COEF_W-1:0]       out_data;
  logic [5:0]              out_index;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    overflow;

  modport master (
    output in_valid, coef_in, out_ready,
    input  in_ready, out_data, out_index, out_valid, out_last, overflow
  );

  modport slave (
    input  in_valid, coef_in, out_ready,
    output in_ready, out_data, out_index, out_valid, out_last, overflow
  );
endinterface

// File: rtl/dct_zigzag_serializer.sv
// Captures one 8x8 DCT block in a single cycle and replays it in JPEG zigzag order.
// Optional DCT_ZZ_EOB_EN: emission stops at the last non-zero zigzag coefficient.
module dct_zigzag_serializer #(
  parameter int COEF_W = 10,
  parameter int NCOEF  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dct_zigzag_serializer_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [COEF_W-1:0] coef_arr [NCOEF];
  logic [COEF_W-1:0] buf_q    [NCOEF];

  state_t            state_q,     state_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic              overflow_q,  overflow_d;
  logic [5:0]        out_index_q, out_index_d;
  logic [COEF_W-1:0] out_data_q,  out_data_d;
  logic [5:0]        last_k_q, last_k_in, k_inc;
  logic              capture;

  generate
    for (genvar gi = 0; gi < NCOEF; gi++) begin : g_unpack
      assign coef_arr[gi] = bus.coef_in[gi*COEF_W +: COEF_W];
    end
  endgenerate

`ifdef DCT_ZZ_EOB_EN
  // Highest zigzag position holding a non-zero value; 0 for an all-zero block.
  always_comb begin
    last_k_in = '0;
    for (int i = 0; i < 64; i++) begin
      if (coef_arr[ZZ[i]] != '0) last_k_in = 6'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_k_q <= '0;
    else if (capture) last_k_q <= last_k_in;
  end
`else
  assign last_k_in = 6'd63;
  assign last_k_q  = 6'd63;
`endif

  assign k_inc = out_index_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q | (bus.in_valid & ~in_ready_q);
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture     = 1'b1;
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_index_d = '0;
          out_data_d  = coef_arr[0];
          out_last_d  = (last_k_in == 6'd0);
        end
      end
      SEND: begin
        // out_valid is always high here, so out_ready alone completes a beat.
        if (bus.out_ready) begin
          if (out_index_q == last_k_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_index_d = k_inc;
            out_data_d  = buf_q[ZZ[k_inc]];
            out_last_d  = (k_inc == last_k_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (capture) buf_q <= coef_arr;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Randomised bench for dct_zigzag_serializer against a diagonal-walk zigzag model.
// Build with +define+DCT_ZZ_EOB_EN to exercise trailing-zero suppression.
module tb_dct_zigzag_serializer;
  localparam int W      = 10;
  localparam int N      = 64;
  localparam int BUDGET = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dct_zigzag_serializer_if #(.COEF_W(W), .NCOEF(N)) bus ();
  dct_zigzag_serializer #(.COEF_W(W), .NCOEF(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int zz [64];
  logic [W-1:0] blk [64];
  logic [W-1:0] exp_data [$];
  int           exp_idx  [$];
  bit           exp_last [$];
  logic [W-1:0] got_data [$];
  int           got_idx  [$];
  bit           got_last [$];
  int stall_err;
  bit timed_out;

  // Zigzag order by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = 8*r + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = 8*r + (s - r); k++; end
      end
    end
  endfunction

  function automatic logic [N*W-1:0] pack_blk();
    logic [N*W-1:0] v = '0;
    for (int p = 0; p < 64; p++) v[p*W +: W] = blk[p];
    return v;
  endfunction

  function automatic void build_expected();
    int n = 64;
`ifdef DCT_ZZ_EOB_EN
    n = 1;
    for (int k = 0; k < 64; k++) if (blk[zz[k]] != '0) n = k + 1;
`endif
    exp_data.delete(); exp_idx.delete(); exp_last.delete();
    for (int k = 0; k < n; k++) begin
      exp_data.push_back(blk[zz[k]]);
      exp_idx.push_back(k);
      exp_last.push_back(k == n - 1);
    end
  endfunction

  // -1 on length mismatch, else number of differing beats.
  function automatic int stream_mismatches();
    int m = 0;
    if (got_data.size() != exp_data.size()) return -1;
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] !== exp_data[i] || got_idx[i] != exp_idx[i] || got_last[i] != exp_last[i]) m++;
    return m;
  endfunction

  function automatic void gen_random(input int tz);
    for (int p = 0; p < 64; p++) blk[p] = W'($urandom);
    for (int k = 64 - tz; k < 64; k++) blk[zz[k]] = '0;
  endfunction

  task automatic send_block();
    bus.coef_in  = pack_blk();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random. Optional block injection at cycle inject_at.
  task automatic collect(input int mode, input int inject_at, input logic [N*W-1:0] inj);
    int c = 0;
    bit done = 0, prev_stall = 0;
    logic [W-1:0] sv_data; logic [5:0] sv_idx; logic sv_last, sv_valid;
    got_data.delete(); got_idx.delete(); got_last.delete();
    stall_err = 0; timed_out = 0;
    while (!done) begin
      if (c >= BUDGET) begin timed_out = 1; break; end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == inject_at) begin bus.coef_in = inj; bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      if (prev_stall && (bus.out_data !== sv_data || bus.out_index !== sv_idx ||
                         bus.out_last !== sv_last || bus.out_valid !== sv_valid)) stall_err++;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_idx.push_back(int'(bus.out_index));
        got_last.push_back(bus.out_last);
        if (bus.out_last) done = 1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      sv_data = bus.out_data; sv_idx = bus.out_index; sv_last = bus.out_last; sv_valid = bus.out_valid;
      @(posedge clk); #1;
      c++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    if (bus.out_index !== 6'd0) begin failures++; $display("FAIL reset_out_index: got %0d expected 0", bus.out_index); end
    if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_ramp();
    int first8 [8] = '{0, 1, 8, 16, 9, 2, 3, 10};
    int mm;
    for (int p = 0; p < 64; p++) blk[p] = W'(p);
    build_expected();
    send_block();
    checks += 3;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ramp_latency_valid: got %b expected 1", bus.out_valid); end
    if (bus.out_index !== 6'd0) begin failures++; $display("FAIL ramp_latency_index: got %0d expected 0", bus.out_index); end
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ramp_busy_in_ready: got %b expected 0", bus.in_ready); end
    collect(0, -1, '0);
    checks += 4;
    if (timed_out) begin failures++; $display("FAIL ramp_timeout: got %0d beats expected 64", got_data.size()); end
    if (got_data.size() != 64) begin failures++; $display("FAIL ramp_count: got %0d expected 64", got_data.size()); end
    else begin
      checks += 8 + 3;
      for (int i = 0; i < 8; i++)
        if (int'(got_data[i]) != first8[i]) begin failures++; $display("FAIL ramp_beat%0d: got %0d expected %0d", i, got_data[i], first8[i]); end
      if (got_data[63] !== 10'd63) begin failures++; $display("FAIL ramp_last_data: got %0d expected 63", got_data[63]); end
      if (got_idx[63] != 63) begin failures++; $display("FAIL ramp_last_index: got %0d expected 63", got_idx[63]); end
      if (got_last[63] != 1'b1) begin failures++; $display("FAIL ramp_last_flag: got %b expected 1", got_last[63]); end
    end
    mm = stream_mismatches();
    if (mm != 0) begin failures++; $display("FAIL ramp_model: got %0d mismatches expected 0", mm); end
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL ramp_return_idle: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    $display("ramp: %0d beats", got_data.size());
  endtask

  task automatic test_backpressure();
    int mm;
    for (int p = 0; p < 64; p++) blk[p] = W'(p);
    build_expected();
    send_block();
    collect(1, -1, '0);
    mm = stream_mismatches();
    checks += 3;
    if (timed_out) begin failures++; $display("FAIL bp_timeout: got %0d beats expected 64", got_data.size()); end
    if (mm != 0) begin failures++; $display("FAIL bp_model: got %0d mismatches expected 0", mm); end
    if (stall_err != 0) begin failures++; $display("FAIL bp_stall_hold: got %0d changes expected 0", stall_err); end
    $display("backpressure: %0d beats", got_data.size());
  endtask

  task automatic test_overflow();
    logic [N*W-1:0] b2;
    int mm;
    gen_random(0);
    b2 = ~pack_blk();
    build_expected();
    send_block();
    collect(0, 10, b2);
    mm = stream_mismatches();
    checks += 3;
    if (timed_out) begin failures++; $display("FAIL ovf_timeout: got %0d beats", got_data.size()); end
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
    if (mm != 0) begin failures++; $display("FAIL ovf_first_block: got %0d mismatches expected 0", mm); end
    gen_random($urandom_range(0, 20));
    build_expected();
    send_block();
    collect(2, -1, '0);
    mm = stream_mismatches();
    checks += 3;
    if (timed_out) begin failures++; $display("FAIL ovf3_timeout: got %0d beats", got_data.size()); end
    if (mm != 0) begin failures++; $display("FAIL ovf_third_block: got %0d mismatches expected 0", mm); end
    if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    $display("overflow: third block %0d beats", got_data.size());
  endtask

  task automatic test_signed();
    gen_random(0);
    blk[0] = 10'h200;
    blk[63] = 10'h1FF;
    build_expected();
    send_block();
    collect(0, -1, '0);
    checks += 1;
    if (got_data.size() != 64) begin failures++; $display("FAIL signed_count: got %0d expected 64", got_data.size()); end
    else begin
      checks += 2;
      if (got_data[0] !== 10'h200) begin failures++; $display("FAIL signed_beat0: got %h expected 200", got_data[0]); end
      if (got_data[63] !== 10'h1FF) begin failures++; $display("FAIL signed_beat63: got %h expected 1ff", got_data[63]); end
    end
    $display("signed: beat0=%h beat63=%h", got_data.size() > 0 ? got_data[0] : 10'h0, got_data.size() > 63 ? got_data[63] : 10'h0);
  endtask

  task automatic test_reset_mid();
    int mm;
    for (int p = 0; p < 64; p++) blk[p] = W'(p + 100);
    send_block();
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks += 1;
    if (bus.out_index !== 6'd20) begin failures++; $display("FAIL rstmid_at_beat20: got %0d expected 20", bus.out_index); end
    rst_n = 1'b0;
    #1;
    checks += 1;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_index !== 6'd0 ||
        bus.out_data !== '0 || bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: got v=%b l=%b i=%0d d=%h o=%b r=%b expected 0/0/0/0/0/1",
               bus.out_valid, bus.out_last, bus.out_index, bus.out_data, bus.overflow, bus.in_ready);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 1;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    gen_random(0);
    build_expected();
    send_block();
    collect(0, -1, '0);
    mm = stream_mismatches();
    checks += 2;
    if (got_idx.size() == 0 || got_idx[0] != 0) begin failures++; $display("FAIL rstmid_restart_index: got %0d beats expected first index 0", got_idx.size()); end
    if (mm != 0) begin failures++; $display("FAIL rstmid_restart_model: got %0d mismatches expected 0", mm); end
    $display("reset_mid: restart %0d beats", got_data.size());
  endtask

  task automatic test_sparse_blocks();
    int mm;
    for (int p = 0; p < 64; p++) blk[p] = '0;
    blk[0] = 10'd5;
    blk[9] = 10'h3FD;
    build_expected();
    send_block();
    collect(2, -1, '0);
    mm = stream_mismatches();
    checks += 1;
    if (mm != 0) begin failures++; $display("FAIL sparse_model: got %0d mismatches expected 0", mm); end
`ifdef DCT_ZZ_EOB_EN
    checks += 1;
    if (got_data.size() != 5 || got_data[4] !== 10'h3FD || got_idx[4] != 4 || got_last[4] != 1'b1) begin
      failures++; $display("FAIL sparse_eob: got %0d beats expected 5 ending -3 at index 4", got_data.size());
    end
`endif
    $display("sparse: %0d beats", got_data.size());
    for (int p = 0; p < 64; p++) blk[p] = '0;
    build_expected();
    send_block();
    collect(0, -1, '0);
    mm = stream_mismatches();
    checks += 1;
    if (mm != 0) begin failures++; $display("FAIL zero_model: got %0d mismatches expected 0", mm); end
`ifdef DCT_ZZ_EOB_EN
    checks += 1;
    if (got_data.size() != 1 || got_data[0] !== '0 || got_idx[0] != 0 || got_last[0] != 1'b1) begin
      failures++; $display("FAIL zero_eob: got %0d beats expected 1 beat idx0 data0 last", got_data.size());
    end
`endif
    $display("zero: %0d beats", got_data.size());
  endtask

  task automatic test_random();
    int mm;
    for (int t = 0; t < 6; t++) begin
      gen_random($urandom_range(0, 63));
      build_expected();
      send_block();
      collect(2, -1, '0);
      mm = stream_mismatches();
      checks += 2;
      if (mm != 0) begin failures++; $display("FAIL rand%0d_model: got %0d mismatches expected 0", t, mm); end
      if (stall_err != 0) begin failures++; $display("FAIL rand%0d_stall_hold: got %0d changes expected 0", t, stall_err); end
      $display("random %0d: %0d beats", t, got_data.size());
    end
  endtask

  initial begin
    build_zz();
    bus.in_valid  = 1'b0;
    bus.coef_in   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ramp();
    test_backpressure();
    test_overflow();
    test_signed();
    test_reset_mid();
    test_sparse_blocks();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dct_zigzag_serializer.md
Name: dct_zigzag_serializer

Overview:
- Downstream consumer of the 2-D DCT stage: captures one full 8x8 block of 10-bit coefficients in the cycle the DCT asserts valid.
- Re-emits the block one coefficient per cycle in JPEG zigzag order over a valid/ready stream.
- Feeds the later quantiser/entropy-coder path.
- Holds one block; the DCT stage has no backpressure, so blocks that arrive while busy are dropped and flagged.

Parameters:
- COEF_W, 10, coefficient width (two's complement, passed through unchanged)
- NCOEF, 64, coefficients per block (fixed 8x8; not meant to be overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  one-cycle pulse, block present on coef_in (driven by the DCT valid)
- coef_in  input  NCOEF*COEF_W  row-major packed block: coefficient (row r, col c) at bits [(8r+c)*COEF_W +: COEF_W]; (0,0) at LSB
- in_ready  output  1  high when a block can be captured
- out_data  output  COEF_W  current coefficient
- out_index  output  6  zigzag index of out_data (0..63)
- out_valid  output  1  out_data/out_index/out_last valid
- out_ready  input  1  downstream accepts the beat
- out_last  output  1  final beat of the block
- overflow  output  1  sticky: a block arrived while in_ready was low

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_last=0, out_index=0, out_data=0, overflow=0; in_ready=1. Buffer contents are don't-care.
- Reset asserted mid-block: the block is abandoned and no further beats are emitted.
- States: IDLE and SEND.
- in_ready = (state==IDLE), registered.
- IDLE:
  - on in_valid, latch all 64 coefficients into the buffer, set zigzag counter k=0, go to SEND.
  - out_valid rises the cycle after capture (latency 1).
- SEND:
  - out_valid=1; out_data = buffer[ZZ[k]]; out_index=k.
  - out_last=1 when k==last_k. last_k=63 by default (see Optional Feature).
  - Beat transfers on out_valid&&out_ready; k increments.
  - While out_ready=0, all outputs hold stable; this is checked.
  - On transfer of the last beat, go to IDLE: out_valid=0 and in_ready=1 the next cycle.
- ZZ table is the standard JPEG zigzag, raster index per k: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- in_valid while in_ready=0 (including the cycle of the last-beat handshake): block ignored, buffer untouched, overflow set to 1. overflow clears only on reset.
- Minimum block period with out_ready held high: 65 cycles (1 capture + 64 beats).
- No arithmetic on coefficients; values pass bit-exact.

Optional Feature:
- Macro: DCT_ZZ_EOB_EN.
- Defined:
  - At capture, compute last_k = highest zigzag index with a non-zero coefficient, registered with the buffer.
  - Emission stops after beat last_k, with out_last on that beat; trailing zeros are suppressed.
  - An all-zero block emits exactly one beat: index 0, data 0, out_last=1.
  - Capture latency is unchanged (still 1 cycle).
- Not defined: last_k is constant 63, and every block emits 64 beats.

Test Plan:
- Ramp block: coefficient at raster p = p; out_ready=1.
  - First beats are 0,1,8,16,9,2,3,10.
  - 64th beat is 63 with out_last=1 and out_index=63.
  - in_ready returns 1 one cycle after the last beat.
- Backpressure: same block; toggle out_ready 1,0,0,1 repeating.
  - Sequence and count are unchanged.
  - Outputs hold stable during every stall.
  - No beat is duplicated or skipped.
- Overflow: second in_valid pulse 10 cycles after the first.
  - overflow=1 and stays 1.
  - Output stream still equals the first block.
  - A third block sent after return to IDLE is emitted correctly.
- Signed passthrough: coef (0,0)=10'h200 (-512), (7,7)=10'h1FF.
  - Beat 0 = 10'h200; beat 63 = 10'h1FF.
- Reset mid-block: assert rst_n low at beat 20.
  - All outputs go to reset values immediately (async), and in_ready=1 after release.
  - A new block then starts again at index 0.
- DCT_ZZ_EOB_EN:
  - Block non-zero only at raster 0 (5) and raster 9 (-3) emits 5 beats: 5,0,0,0,-3, last on index 4.
  - All-zero block emits one beat: index 0, data 0, with out_last=1.
